// File: rtl/pipelined_hash_validator.sv
// Multi-lane pipelined double-SHA256 target checker with difficulty reload and sticky first-hit capture.
module pipelined_hash_validator #(
   parameter int unsigned LANES = 4,
   parameter int unsigned TAG_W = 32,
   parameter int unsigned CHUNK = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      diff_load,
   input  logic [31:0]                               difficulty,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [256*LANES-1:0]                      in_hash,
   input  logic [TAG_W-1:0]                          in_tag,
   output logic                                      out_valid,
   output logic [LANES-1:0]                          out_hit,
   output logic [TAG_W-1:0]                          out_tag,
   output logic                                      diff_invalid,
   output logic                                      found,
   output logic [TAG_W-1:0]                          found_tag,
   output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] found_lane,
   input  logic                                      found_clr
);

   localparam int unsigned S  = 256 / CHUNK;
   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t           state, state_n;
   logic             load_c;
   logic [255:0]     target;
   logic [255:0]     target_c;
   logic             invalid_c;
   logic [7:0]       exp_c;
   logic [23:0]      mant_c;

   // Pipeline registers: index j feeds compare stage j (index 0 is the input register)
   logic [S-1:0]     vld;
   logic [TAG_W-1:0] tag_q [S];
   logic [255:0]     num_q [S][LANES];
   logic [LANES-1:0] dec_q [S];
   logic [LANES-1:0] lt_q  [S];
   logic [LANES-1:0] dec_n [S];
   logic [LANES-1:0] lt_n  [S];
   logic [255:0]     num_in [LANES];
   logic [LW-1:0]    pick [LANES+1];

   // Byte-reverse each digest into its numeric value
   for (genvar l = 0; l < LANES; l++) begin : g_swap
      for (genvar k = 0; k < 32; k++) begin : g_byte
         assign num_in[l][8*k +: 8] = in_hash[256*l + 255 - 8*k -: 8];
      end
   end

   // Per-stage chunk compare; a lane keeps the first differing chunk's verdict
   for (genvar j = 0; j < S; j++) begin : g_cmp
      localparam int unsigned HI = 255 - j * CHUNK;
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic [CHUNK-1:0] a, b;
         assign a           = num_q[j][l][HI -: CHUNK];
         assign b           = target[HI -: CHUNK];
         assign dec_n[j][l] = dec_q[j][l] | (a != b);
         assign lt_n[j][l]  = dec_q[j][l] ? lt_q[j][l] : (a < b);
      end
   end

   // Input register control: accept a beat only while ready
   always_ff @(posedge clk) begin
      if (rst) begin
         vld[0]   <= 1'b0;
         dec_q[0] <= '0;
         lt_q[0]  <= '0;
      end else begin
         vld[0]   <= in_valid & in_ready;
         dec_q[0] <= '0;
         lt_q[0]  <= '0;
      end
   end

   // Input register payload
   always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
      num_q[0] <= num_in;
   end

   for (genvar j = 1; j < S; j++) begin : g_stage
      // Stage control flags advance every cycle
      always_ff @(posedge clk) begin
         if (rst) begin
            vld[j]   <= 1'b0;
            dec_q[j] <= '0;
            lt_q[j]  <= '0;
         end else begin
            vld[j]   <= vld[j-1];
            dec_q[j] <= dec_n[j-1];
            lt_q[j]  <= lt_n[j-1];
         end
      end

      // Stage payload travels with its beat
      always_ff @(posedge clk) begin
         tag_q[j] <= tag_q[j-1];
         num_q[j] <= num_q[j-1];
      end
   end

   // Result register; undecided lanes equal the target and therefore miss
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_hit   <= '0;
         out_tag   <= '0;
      end else begin
         out_valid <= vld[S-1];
         out_hit   <= vld[S-1] ? (lt_n[S-1] & dec_n[S-1]) : '0;
         if (vld[S-1]) out_tag <= tag_q[S-1];
      end
   end

   // Control state register; in_ready mirrors the RUN state
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         in_ready <= 1'b1;
      end else begin
         state    <= state_n;
         in_ready <= (state_n == RUN);
      end
   end

   // Next-state: drain in-flight beats before swapping the target
   always_comb begin
      state_n = state;
      load_c  = 1'b0;
      case (state)
         RUN:     if (diff_load) state_n = DRAIN;
         DRAIN:   if (vld == '0) state_n = LOAD;
         LOAD: begin
            load_c  = 1'b1;
            state_n = RUN;
         end
         default: state_n = RUN;
      endcase
   end

   // Compact difficulty decode
   always_comb begin
      exp_c     = difficulty[7:0];
      mant_c    = {difficulty[15:8], difficulty[23:16], difficulty[31:24]};
      target_c  = '0;
      invalid_c = 1'b0;
      if (exp_c > 8'd32) begin
         invalid_c = 1'b1;
      end else if (exp_c >= 8'd3) begin
         target_c = 256'(mant_c) << {8'(exp_c - 8'd3), 3'b000};
      end else begin
         target_c = 256'(mant_c) >> {8'(8'd3 - exp_c), 3'b000};
      end
   end

   // Target register, written only in LOAD
   always_ff @(posedge clk) begin
      if (rst) begin
         target       <= '0;
         diff_invalid <= 1'b0;
      end else if (load_c) begin
         target       <= target_c;
         diff_invalid <= invalid_c;
      end
   end

   // Lowest hitting lane of the reported beat
   assign pick[LANES] = '0;
   for (genvar i = 0; i < LANES; i++) begin : g_pick
      assign pick[i] = out_hit[i] ? LW'(i) : pick[i+1];
   end

   // Sticky first-hit capture; a simultaneous hit wins over the clear
   always_ff @(posedge clk) begin
      if (rst) begin
         found      <= 1'b0;
         found_tag  <= '0;
         found_lane <= '0;
      end else if (out_valid && (|out_hit) && (!found || found_clr)) begin
         found      <= 1'b1;
         found_tag  <= out_tag;
         found_lane <= pick[0];
      end else if (found_clr) begin
         found <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipelined_hash_validator.sv
// Scoreboard bench for pipelined_hash_validator.
module tb_pipelined_hash_validator;

   localparam int LANES = 4;
   localparam int TAG_W = 32;
   localparam int CHUNK = 64;
   localparam int S     = 256 / CHUNK;

   typedef logic [LANES-1:0][255:0] beat_t;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [LANES-1:0] hit;
   } exp_t;

   logic                 clk, rst, diff_load, in_valid, in_ready;
   logic [31:0]          difficulty;
   logic [256*LANES-1:0] in_hash;
   logic [TAG_W-1:0]     in_tag, out_tag, found_tag;
   logic                 out_valid, diff_invalid, found, found_clr;
   logic [LANES-1:0]     out_hit;
   logic [1:0]           found_lane;

   exp_t         sb[$];
   int           checks = 0;
   int           passes = 0;
   int           outs   = 0;
   logic [255:0] cur_tgt = '0;

   pipelined_hash_validator #(.LANES(LANES), .TAG_W(TAG_W), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .diff_load(diff_load), .difficulty(difficulty),
      .in_valid(in_valid), .in_ready(in_ready), .in_hash(in_hash), .in_tag(in_tag),
      .out_valid(out_valid), .out_hit(out_hit), .out_tag(out_tag),
      .diff_invalid(diff_invalid), .found(found), .found_tag(found_tag),
      .found_lane(found_lane), .found_clr(found_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1);
   end

   function automatic logic [255:0] rev(input logic [255:0] x);
      logic [255:0] r;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = x[255-8*k -: 8];
      return r;
   endfunction

   // Byte-placement model of the compact target
   function automatic logic [255:0] model_target(input logic [31:0] d);
      logic [255:0] t;
      logic [7:0]   mb [3];
      int           e;
      t = '0;
      e = int'(d[7:0]);
      mb[0] = d[31:24];
      mb[1] = d[23:16];
      mb[2] = d[15:8];
      if (e <= 32) begin
         for (int i = 0; i < 3; i++) begin
            int p;
            p = e - 3 + i;
            if (p >= 0) t[p*8 +: 8] = mb[i];
         end
      end
      return t;
   endfunction

   // Result monitor: pops the oldest expectation on every strobe
   always @(negedge clk) begin
      exp_t e;
      if (out_valid === 1'b1) begin
         outs++;
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_out: got tag=%h hit=%b, required no output", out_tag, out_hit);
         end else begin
            e = sb.pop_front();
            if (out_tag !== e.tag || out_hit !== e.hit)
               $display("FAIL result: got tag=%h hit=%b, required tag=%h hit=%b", out_tag, out_hit, e.tag, e.hit);
            else
               passes++;
         end
      end
   end

   task automatic send(input beat_t b, input logic [TAG_W-1:0] tag, input bit do_load, input logic [31:0] nd);
      exp_t x;
      bit   acc;
      acc      = 1'b0;
      in_hash  = b;
      in_tag   = tag;
      in_valid = 1'b1;
      if (do_load) begin
         diff_load  = 1'b1;
         difficulty = nd;
      end
      for (int c = 0; c < 200 && !acc; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      diff_load = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL send_timeout: tag=%h in_ready=%b, required acceptance", tag, in_ready);
      end else begin
         x.tag = tag;
         for (int l = 0; l < LANES; l++) x.hit[l] = (rev(b[l]) < cur_tgt);
         sb.push_back(x);
         if (do_load) cur_tgt = model_target(nd);
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (sb.size() != 0 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [31:0] d);
      int low;
      bit up;
      low = 0;
      up  = 1'b0;
      drain();
      difficulty = d;
      diff_load  = 1'b1;
      @(posedge clk); #1;
      diff_load = 1'b0;
      for (int c = 0; c < 50 && !up; c++) begin
         @(negedge clk);
         if (in_ready) up = 1'b1; else low++;
         @(posedge clk); #1;
      end
      cur_tgt = model_target(d);
      checks++;
      if (low != 2) $display("FAIL reload_cost: in_ready low %0d cycles, required 2", low);
      else passes++;
      checks++;
      if (diff_invalid !== (d[7:0] > 8'd32))
         $display("FAIL diff_invalid: got %b, required %b", diff_invalid, (d[7:0] > 8'd32));
      else passes++;
   endtask

   task automatic test_reset();
      beat_t b;
      checks++;
      if ({in_ready, out_valid, found, diff_invalid} !== 4'b1000)
         $display("FAIL reset_flags: got %b, required 1000", {in_ready, out_valid, found, diff_invalid});
      else passes++;
      checks++;
      if ({out_hit, found_lane} !== '0) $display("FAIL reset_hit_lane: got %h, required 0", {out_hit, found_lane});
      else passes++;
      checks++;
      if ({out_tag, found_tag} !== '0) $display("FAIL reset_tags: got %h, required 0", {out_tag, found_tag});
      else passes++;
      b = '0;
      send(b, 32'h1, 1'b0, 32'h0);
      drain();
   endtask

   task automatic test_genesis();
      beat_t b;
      int    k;
      load(32'hFFFF001D);
      b = '0;
      b[0][39:32] = 8'hFF;
      b[0][47:40] = 8'hFE;
      b[1] = '1;
      b[3] = rev(cur_tgt);
      send(b, 32'h10, 1'b0, 32'h0);
      k = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k != S + 1) $display("FAIL latency: out_valid in cycle n+%0d, required n+%0d", k, S + 1);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (found !== 1'b1 || found_tag !== 32'h10 || found_lane !== 2'd0)
         $display("FAIL genesis_found: got %b/%h/%0d, required 1/00000010/0", found, found_tag, found_lane);
      else passes++;
      drain();
   endtask

   task automatic test_equality();
      beat_t b;
      b = '0;
      b[0] = rev(cur_tgt);
      b[1][31:24] = 8'h01;
      b[2] = rev(cur_tgt - 256'd1);
      b[3] = rev(cur_tgt | 256'd1);
      send(b, 32'h20, 1'b0, 32'h0);
      drain();
   endtask

   task automatic test_back_to_back();
      beat_t        b;
      logic [255:0] one;
      one = 256'd1;
      for (int i = 0; i < 6; i++) begin
         for (int l = 0; l < LANES; l++) b[l] = rev(cur_tgt ^ (one << $urandom_range(0, 255)));
         send(b, TAG_W'($urandom), 1'b0, 32'h0);
      end
      drain();
   endtask

   task automatic test_reload();
      beat_t b;
      int    outs0;
      outs0 = outs;
      b = '0;
      b[0] = rev(256'd1 << 224);
      b[1] = rev(256'hFFFF << 232);
      b[2] = rev(256'hFFFF << 220);
      b[3] = rev(256'hFFFE << 208);
      for (int i = 0; i < 8; i++) begin
         send(b, TAG_W'(32'h100 + i), (i == 3), 32'hFFFF0020);
         if (i == 3) begin
            checks++;
            if (in_ready !== 1'b0) $display("FAIL reload_ready: got %b after load, required 0", in_ready);
            else passes++;
         end
      end
      drain();
      checks++;
      if (outs - outs0 != 8) $display("FAIL reload_count: got %0d outputs, required 8", outs - outs0);
      else passes++;
   endtask

   task automatic test_exponent();
      beat_t b;
      load(32'h56341202);
      b[0] = rev(256'h1233);
      b[1] = rev(256'h1234);
      b[2] = '0;
      b[3] = rev(256'h1235);
      send(b, 32'h30, 1'b0, 32'h0);
      load(32'h56341221);
      b[0] = '0;
      b[1] = rev(256'd1);
      send(b, 32'h31, 1'b0, 32'h0);
      drain();
   endtask

   task automatic test_sticky();
      beat_t b;
      bit    seen;
      load(32'hFFFF001D);
      found_clr = 1'b1;
      @(posedge clk); #1;
      found_clr = 1'b0;
      checks++;
      if (found !== 1'b0) $display("FAIL clear: found=%b, required 0", found);
      else passes++;
      b = '1;
      b[2] = '0;
      b[3] = '0;
      send(b, 32'hA0, 1'b0, 32'h0);
      b = '1;
      b[1] = '0;
      send(b, 32'hB0, 1'b0, 32'h0);
      drain();
      checks++;
      if (found !== 1'b1 || found_tag !== 32'hA0 || found_lane !== 2'd2)
         $display("FAIL first_hit: got %b/%h/%0d, required 1/000000a0/2", found, found_tag, found_lane);
      else passes++;
      send(b, 32'hB1, 1'b0, 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1; else begin @(posedge clk); #1; end
      end
      found_clr = 1'b1;
      @(posedge clk); #1;
      found_clr = 1'b0;
      checks++;
      if (!seen || found !== 1'b1 || found_tag !== 32'hB1 || found_lane !== 2'd1)
         $display("FAIL clr_vs_hit: seen=%b got %b/%h/%0d, required 1/000000b1/1", seen, found, found_tag, found_lane);
      else passes++;
      drain();
   endtask

   task automatic test_reset_mid();
      beat_t b;
      int    outs0;
      b = '0;
      for (int i = 0; i < 3; i++) send(b, TAG_W'(32'hC0 + i), 1'b0, 32'h0);
      outs0 = outs;
      rst = 1'b1;
      sb.delete();
      cur_tgt = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, found, diff_invalid, out_hit, found_lane} !== {4'b1000, 6'b0})
         $display("FAIL midreset_flags: got %b, required 1000000000",
                  {in_ready, out_valid, found, diff_invalid, out_hit, found_lane});
      else passes++;
      checks++;
      if ({out_tag, found_tag} !== '0) $display("FAIL midreset_tags: got %h, required 0", {out_tag, found_tag});
      else passes++;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (outs != outs0) $display("FAIL midreset_flush: %0d outputs after reset, required 0", outs - outs0);
      else passes++;
      send(b, 32'hD0, 1'b0, 32'h0);
      drain();
   endtask

   initial begin
      rst        = 1'b1;
      diff_load  = 1'b0;
      difficulty = '0;
      in_valid   = 1'b0;
      in_hash    = '0;
      in_tag     = '0;
      found_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_genesis();
      test_equality();
      test_back_to_back();
      test_reload();
      test_exponent();
      test_sticky();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_hash_validator.md
# pipelined_hash_validator

Multi-lane, pipelined successor to the single-hash validator. Each cycle it accepts up to `LANES` double-SHA256 digests sharing one nonce tag and checks each against the target decoded from a compact difficulty word. The block sits between the hash cores and the result reporter. It adds valid/ready input handshaking, safe difficulty reload, out-of-range exponent detection, and a sticky first-hit capture.

## Interface
- `LANES`, default 4: digests checked in parallel per beat.
- `TAG_W`, default 32: width of the nonce tag carried with each beat.
- `CHUNK`, default 64: compare width per pipeline stage. Must divide 256. `S = 256/CHUNK` compare stages.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `diff_load`  in  1  request to load `difficulty`.
- `difficulty`  in  32  compact target word. Sampled only when the load is committed.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_hash`  in  256×LANES  digests. Lane i occupies bits `[256i+255:256i]`.
- `in_tag`  in  TAG_W  nonce tag of the beat.
- `out_valid`  out  1  one-cycle result strobe.
- `out_hit`  out  LANES  per-lane result: hash < target.
- `out_tag`  out  TAG_W  tag of the reported beat.
- `diff_invalid`  out  1  the loaded exponent is out of range.
- `found`  out  1  sticky: some lane hit since the last clear.
- `found_tag`  out  TAG_W  tag of the first hit.
- `found_lane`  out  $clog2(LANES)  lowest hitting lane of that first beat.
- `found_clr`  in  1  clears `found`.

## Operation
- **Hash interpretation.** The digest is byte-reversed to form the number. Number byte k = `in_hash[255-8k : 248-8k]` of the lane. The most significant byte of the number is therefore `hash[7:0]`.
- **Difficulty decode.**
  - Exponent `e` = `difficulty[7:0]`.
  - Mantissa `m` = `{difficulty[15:8], difficulty[23:16], difficulty[31:24]}`, 24 bits.
  - `target` (256 bits) = `m << 8(e−3)` for 3 ≤ e ≤ 32.
  - `target` = `m >> 8(3−e)` for e < 3.
  - For e > 32: `target` = 0 and `diff_invalid` = 1, so every lane misses.
  - The decoded target is held in a register. Comparison is strictly less-than.
- **Control FSM** (states RUN, DRAIN, LOAD).
  - RUN: `in_ready` = 1. On `diff_load`, go to DRAIN. A beat presented in the same cycle as `diff_load` is accepted and checked against the old target.
  - DRAIN: `in_ready` = 0. Remain until the pipeline holds no valid beat, then go to LOAD.
  - LOAD: `in_ready` = 0. Register `target` and `diff_invalid` from `difficulty` as sampled this cycle, then return to RUN.
  - `diff_load` asserted during DRAIN or LOAD is ignored. The difficulty value is taken in LOAD.
- **Compare pipeline.**
  - An input register is followed by S stages. Stage j compares number bits `[255−j·CHUNK −: CHUNK]` of each lane against the same bits of `target`.
  - Each stage carries per-lane `decided` and `lt` flags forward. Once a lane is decided, later stages keep its result. A lane still undecided after the last stage is equal to the target, so it misses.
  - Each beat's valid bit, tag and lane data travel with it.
- **Sticky capture.**
  - When `out_valid` & |`out_hit` & !`found`: set `found`, latch `found_tag` = `out_tag` and `found_lane` = lowest set index of `out_hit`.
  - While `found` = 1, later hits do not overwrite.
  - `found_clr` clears `found`. If a hit arrives in the same cycle as `found_clr`, that hit is captured: the set takes priority over the clear.
- **Reset values.** After `rst`:
  - Outputs: `in_ready`=1, `out_valid`=0, `out_hit`=0, `out_tag`=0, `found`=0, `found_tag`=0, `found_lane`=0, `diff_invalid`=0.
  - Internal: `target`=0, FSM=RUN, all pipeline valid bits 0.
  - The block misses every hash until the first load.
- **Reset mid-operation.** In-flight beats are discarded with no `out_valid`, and any pending load is abandoned.

## Timing
- Latency: a beat accepted (`in_valid`&`in_ready`) in cycle n produces `out_valid` in cycle n+S+1. With the default CHUNK=64 this is n+5.
- Throughput: one beat per cycle in RUN. There is no output backpressure and `out_valid` lasts one cycle per beat.
- Difficulty reload with a full pipeline: `in_ready` is low from cycle n+1 (`diff_load` in n) until the last in-flight `out_valid` has passed, plus the LOAD cycle.
  - Reload cost with an empty pipeline: `in_ready` is low in cycles n+1 (DRAIN) and n+2 (LOAD), and high again in n+3.
- `found`, `found_tag` and `found_lane` update in the cycle after the qualifying `out_valid`.

## Test plan
- **Genesis target.** Load `difficulty`=0xFFFF001D, giving target 0xFFFF<<208. Lane 0 hash has `[39:32]`=0xFF, `[47:40]`=0xFE, rest 0, tag 0x10 → `out_hit`[0]=1 in cycle n+5, `found_tag`=0x10, `found_lane`=0.
- **Equality and near-miss.** Same target. A hash exactly equal to the target → miss. A hash with `[31:24]`=0x01, rest 0 (number ≥ 2^224) → miss.
- **Reload under traffic.** Stream 8 beats, then assert `diff_load` with 0xFFFF0020 on beat 3. Required: beats 0–3 are judged against the old target and beats 4–7 against the new one; `in_ready` is low through DRAIN/LOAD; no beat is lost or duplicated.
- **Exponent edges.** e=0x02, mantissa 0x123456 → target 0x1234: hash number 0x1233 hits, 0x1234 misses. e=0x21 → `diff_invalid`=1 and all lanes miss.
- **Sticky capture.** Hits occur in lanes 2 and 3 of beat A, then in lane 1 of beat B → `found_lane`=2 and the tag of A. `found_clr` in the same cycle as B's `out_valid` → B is captured.
- **Reset mid-stream.** Assert `rst` with 3 beats in flight → no `out_valid` afterwards, all outputs at their reset values, `target`=0.
